gmii_rx_fcs_check: RTL

Receive-side framing stage between the PHY GMII receive pins and the UDP receive engine. Works in the `e_rxc` domain. Strips preamble and SFD, and removes the 4-byte FCS. Checks CRC-32 over destination MAC through FCS, and delivers the remaining bytes as a byte stream with start/end markers and a good/bad verdict on the last byte. The UDP engine consumes this stream instead of raw `e_rxd`/`e_rxdv`, so corrupted frames never reach the RAM.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/crc32_d8.sv | 31 +++
 rtl/gmii_rx_fcs_check.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet framing constants and receive FSM encoding
//
// Purpose: constants for preamble/SFD detection and CRC-32 checking, plus the
//          state encoding of the GMII receive framing FSM.
// Ports:   none (package).
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational CRC-32 next state for one byte, LSB first
//
// Purpose: advances an Ethernet CRC-32 register by one byte. The register is
//          kept in normal (MSB-aligned) bit order while data bits are fed
//          LSB first, so a frame checked through its own FCS leaves the
//          register at 0xC704DD7B.
// Ports:
//   crc_in   in  32  current CRC register
//   data_in  in  8   byte to absorb, bit 0 enters first
//   crc_out  out 32  CRC register after absorbing data_in
module crc32_d8 (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_work;

    always_comb begin
        crc_work = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_work[31] ^ data_in[i]) begin
                crc_work = {crc_work[30:0], 1'b0} ^ 32'h04C11DB7;
            end else begin
                crc_work = {crc_work[30:0], 1'b0};
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/gmii_rx_fcs_check.sv
// rtl/gmii_rx_fcs_check.sv - GMII receive preamble strip, FCS check and removal
//
// Purpose: strips preamble/SFD from the GMII receive stream, checks CRC-32
//          from destination MAC through FCS, drops the FCS via a 5-byte delay
//          line and delivers payload bytes with sof/eof and a good/bad verdict
//          on the last byte. Optional frame statistics with RX_STATS_EN.
// Ports:
//   e_rxc          in  1   GMII receive clock (only clock)
//   reset_n        in  1   asynchronous active-low reset
//   e_rxdv         in  1   GMII receive data valid
//   e_rxer         in  1   GMII receive error
//   e_rxd          in  8   GMII receive data
//   rx_data        out 8   payload byte
//   rx_valid       out 1   rx_data valid
//   rx_sof         out 1   first byte of frame
//   rx_eof         out 1   last payload byte
//   rx_good        out 1   verdict good, only with rx_eof
//   rx_bad         out 1   verdict bad, only with rx_eof
//   frame_ok_cnt   out 16  saturating good-frame count (RX_STATS_EN only)
//   frame_err_cnt  out 16  saturating errored-frame count (RX_STATS_EN only)
module gmii_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        e_rxc,
    input  logic        reset_n,
    input  logic        e_rxdv,
    input  logic        e_rxer,
    input  logic [7:0]  e_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic        rx_bad
`ifdef RX_STATS_EN
    ,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_err_cnt
`endif
);

    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
    localparam logic [10:0] FCS_LAG  = 11'd5;
    localparam logic [10:0] CNT_SAT  = 11'h7FF;

    rx_state_e       state_q, state_d;
    logic [31:0]     crc_q, crc_d, crc_next;
    logic [10:0]     cnt_q, cnt_d;
    logic            rxer_seen_q, rxer_seen_d;
    logic [4:0][7:0] dly_q, dly_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            sof_q, sof_d;
    logic            eof_q, eof_d;
    logic            good_q, good_d;
    logic            bad_q, bad_d;
    logic            drop_entry;
    logic            runt_end;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (e_rxd),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        rxer_seen_d = rxer_seen_q;
        dly_d       = dly_q;
        data_d      = 8'h00;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        good_d      = 1'b0;
        bad_d       = 1'b0;
        drop_entry  = 1'b0;
        runt_end    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (e_rxdv) begin
                    if (e_rxd == ETH_PREAMBLE) begin
                        state_d = ST_PREAMBLE;
                    end else begin
                        state_d    = ST_DROP;
                        drop_entry = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!e_rxdv) begin
                    state_d = ST_IDLE;
                end else if (e_rxd == ETH_SFD) begin
                    state_d     = ST_DATA;
                    crc_d       = CRC32_INIT;
                    cnt_d       = 11'd0;
                    rxer_seen_d = 1'b0;
                end else if (e_rxd != ETH_PREAMBLE) begin
                    state_d    = ST_DROP;
                    drop_entry = 1'b1;
                end
            end
            ST_DATA: begin
                if (e_rxdv) begin
                    crc_d = crc_next;
                    dly_d = {dly_q[3:0], e_rxd};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 11'd1;
                    end
                    if (e_rxer) begin
                        rxer_seen_d = 1'b1;
                    end
                    // The byte leaving the line is 5 behind the one entering,
                    // so the last 4 bytes (FCS) are still inside at end of frame.
                    if (cnt_q >= FCS_LAG) begin
                        data_d  = dly_q[4];
                        valid_d = 1'b1;
                        sof_d   = (cnt_q == FCS_LAG);
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (cnt_q >= FCS_LAG) begin
                        data_d  = dly_q[4];
                        valid_d = 1'b1;
                        sof_d   = (cnt_q == FCS_LAG);
                        eof_d   = 1'b1;
                        good_d  = (crc_q == CRC32_RESIDUE) && (cnt_q >= MIN_LEN) &&
                                  (cnt_q <= MAX_LEN) && !rxer_seen_q;
                        bad_d   = !good_d;
                    end else begin
                        runt_end = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!e_rxdv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge e_rxc or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= CRC32_INIT;
            cnt_q       <= 11'd0;
            rxer_seen_q <= 1'b0;
            dly_q       <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            rxer_seen_q <= rxer_seen_d;
            dly_q       <= dly_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_sof   = sof_q;
    assign rx_eof   = eof_q;
    assign rx_good  = good_q;
    assign rx_bad   = bad_q;

`ifdef RX_STATS_EN
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (good_d && ok_cnt_q != 16'hFFFF) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
        end
        if ((bad_d || runt_end || drop_entry) && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge e_rxc or negedge reset_n) begin
        if (!reset_n) begin
            ok_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign frame_ok_cnt  = ok_cnt_q;
    assign frame_err_cnt = err_cnt_q;
`endif

endmodule
